// File: rtl/fft_frame_buffer_if.sv
// Sample-side and FFT-side signals of the FFT frame buffer, grouped as one bundle.
// With FRAME_DROP_COUNT_EN defined the bundle also carries the 8-bit drop_count.
interface fft_frame_buffer_if #(
  parameter int WIDTH = 12,
  parameter int N     = 16
);
  // sample_valid has no ready partner: the buffer accepts every valid sample
  // unless a complete frame is still waiting for the FFT. In that case the
  // sample is dropped and overrun is raised. start is a level request that
  // stays high until the FFT answers with done.
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic [WIDTH-1:0] frame_samples [0:N-1];
  logic             start;
  logic             done;
  logic             overrun;
`ifdef FRAME_DROP_COUNT_EN
  logic [7:0]       drop_count;

  modport master (output sample_in, sample_valid, done,
                  input  frame_samples, start, overrun, drop_count);
  modport slave  (input  sample_in, sample_valid, done,
                  output frame_samples, start, overrun, drop_count);
`else
  modport master (output sample_in, sample_valid, done,
                  input  frame_samples, start, overrun);
  modport slave  (input  sample_in, sample_valid, done,
                  output frame_samples, start, overrun);
`endif
endinterface

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer: it collects N samples into one bank while the other bank feeds the FFT.
// Optional macro FRAME_DROP_COUNT_EN adds a saturating 8-bit count of dropped samples.
module fft_frame_buffer #(
  parameter int WIDTH = 12,
  parameter int N     = 16
) (
  input  logic               clk,
  input  logic               rst,
  fft_frame_buffer_if.slave  bus,
  output logic               state_dbg
);
  localparam int PW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_next;
  logic [PW-1:0]    wr_ptr;
  logic             frame_ready;
  logic             bank_sel;      // index of the bank being written
  logic             overrun_q;
  logic [WIDTH-1:0] bank [0:1][0:N-1];

  logic accept, drop, last_write, swap, rd_sel;

  assign accept     = bus.sample_valid && !frame_ready;
  assign drop       = bus.sample_valid &&  frame_ready;
  assign last_write = accept && (wr_ptr == PW'(N - 1));
  assign swap       = (state == IDLE) && frame_ready;
  assign rd_sel     = ~bank_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // done is only meaningful while a frame is being transformed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_ready) state_next = RUN;
      RUN:     if (bus.done)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.start = (state == RUN);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      frame_ready <= 1'b0;
      bank_sel    <= 1'b0;
      overrun_q   <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++)
          bank[b][i] <= '0;
    end else begin
      if (accept) begin
        bank[bank_sel][wr_ptr] <= bus.sample_in;
        wr_ptr <= last_write ? '0 : wr_ptr + 1'b1;
      end
      // swap needs frame_ready=1 and last_write needs frame_ready=0, so at most one applies.
      if (swap)            frame_ready <= 1'b0;
      else if (last_write) frame_ready <= 1'b1;
      if (swap) bank_sel  <= ~bank_sel;
      if (drop) overrun_q <= 1'b1;
    end
  end

  assign bus.overrun = overrun_q;

  // The read bank is written only after it becomes the write bank, so the frame holds through RUN.
  always_comb begin
    for (int i = 0; i < N; i++)
      bus.frame_samples[i] = bank[rd_sel][i];
  end

`ifdef FRAME_DROP_COUNT_EN
  logic [7:0] drop_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               drop_count_q <= 8'd0;
    else if (drop && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
  end

  assign bus.drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer: directed scenarios plus a random phase, with every cycle
// compared against a queue-based frame model.
module tb_fft_frame_buffer;
  localparam int WIDTH = 12;
  localparam int N     = 16;
  localparam int FW    = WIDTH * N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic state_dbg;

  fft_frame_buffer_if #(.WIDTH(WIDTH), .N(N)) bus ();

  fft_frame_buffer #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] fill_q[$];      // samples of the frame being collected
  logic [FW-1:0]    exp_q[$];       // complete frames waiting for the FFT
  logic [FW-1:0]    m_pres;         // frame the FFT should be seeing
  bit               m_run;
  bit               m_ovr;
  int               m_drops;

  int frame_a [N] = '{-163, 35, 196, -128, 55, 193, 3, -67,
                      135, -56, -71, -129, 37, 190, 81, -22};
  logic [WIDTH-1:0] f_ref[$];

  function automatic logic [WIDTH-1:0] sx(input int v);
    return v[WIDTH-1:0];
  endfunction

  function automatic logic [FW-1:0] pack_q(input logic [WIDTH-1:0] q[$]);
    logic [FW-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*WIDTH +: WIDTH] = q[i];
    return r;
  endfunction

  function automatic logic [FW-1:0] dut_frame();
    logic [FW-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*WIDTH +: WIDTH] = bus.frame_samples[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    fill_q.delete();
    exp_q.delete();
    m_pres  = '0;
    m_run   = 1'b0;
    m_ovr   = 1'b0;
    m_drops = 0;
  endtask

  // One clock edge of the buffer's behaviour, described with frames rather than pointers.
  task automatic model_step(input logic v, input logic [WIDTH-1:0] s, input logic d);
    bit was_ready = (exp_q.size() != 0);
    if (m_run && d) m_run = 1'b0;
    else if (!m_run && was_ready) begin
      m_pres = exp_q.pop_front();
      m_run  = 1'b1;
    end
    if (v) begin
      if (was_ready) begin
        m_ovr = 1'b1;
        if (m_drops < 255) m_drops++;
      end else begin
        fill_q.push_back(s);
        if (fill_q.size() == N) begin
          exp_q.push_back(pack_q(fill_q));
          fill_q.delete();
        end
      end
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, ":start"},   FW'(bus.start),   FW'(m_run));
    check({ph, ":state"},   FW'(state_dbg),   FW'(m_run));
    check({ph, ":overrun"}, FW'(bus.overrun), FW'(m_ovr));
    check({ph, ":frame"},   dut_frame(),      m_pres);
`ifdef FRAME_DROP_COUNT_EN
    check({ph, ":drops"},   FW'(bus.drop_count), FW'(m_drops));
`endif
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic [WIDTH-1:0] s, input logic d, input string ph);
    bus.sample_valid = v;
    bus.sample_in    = s;
    bus.done         = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
    compare_all(ph);
  endtask

  task automatic reset_outputs_zero(input string ph);
    check({ph, ":rst_start"},   FW'(bus.start),   '0);
    check({ph, ":rst_overrun"}, FW'(bus.overrun), '0);
    check({ph, ":rst_state"},   FW'(state_dbg),   '0);
    check({ph, ":rst_frame"},   dut_frame(),      '0);
`ifdef FRAME_DROP_COUNT_EN
    check({ph, ":rst_drops"},   FW'(bus.drop_count), '0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] s;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.done         = 1'b0;
    model_reset();
    #1;
    reset_outputs_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Done in IDLE is ignored.
    cycle(1'b0, '0, 1'b1, "idle_done");
    check("idle_done_start", FW'(bus.start), '0);
    cycle(1'b0, '0, 1'b0, "idle_after");

    // Fill the first frame with the reference samples.
    for (int i = 0; i < N; i++) cycle(1'b1, sx(frame_a[i]), 1'b0, "fill");
    check("fill_start_low_at_16th", FW'(bus.start), '0);
    cycle(1'b0, '0, 1'b0, "fill_swap");
    check("fill_start_high", FW'(bus.start), FW'(1));
    check("fill_f0",  FW'(bus.frame_samples[0]),  FW'(sx(-163)));
    check("fill_f15", FW'(bus.frame_samples[15]), FW'(sx(-22)));

    // Hold: 40 cycles without done while 10 samples start the second frame.
    f_ref.delete();
    for (int i = 0; i < 40; i++) begin
      s = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      if (i < 10) f_ref.push_back(s);
      cycle(i < 10, s, 1'b0, "hold");
    end
    for (int i = 0; i < N; i++) f_ref.push_front(sx(frame_a[N-1-i]));
    check("hold_frame", dut_frame(), pack_q(f_ref[0:N-1]));
    check("hold_start", FW'(bus.start), FW'(1));
    check("hold_overrun", FW'(bus.overrun), '0);
    f_ref = f_ref[N:$];

    // Overrun: complete the second frame, then three samples with no room.
    for (int i = 0; i < 6; i++) begin
      s = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      f_ref.push_back(s);
      cycle(1'b1, s, 1'b0, "fill2");
    end
    for (int i = 0; i < 3; i++)
      cycle(1'b1, WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), 1'b0, "drop");
    check("ovr_flag", FW'(bus.overrun), FW'(1));
`ifdef FRAME_DROP_COUNT_EN
    check("ovr_count", FW'(bus.drop_count), FW'(3));
`endif
    cycle(1'b0, '0, 1'b1, "ovr_done");
    check("ovr_start_low", FW'(bus.start), '0);
    cycle(1'b0, '0, 1'b0, "ovr_swap");
    check("ovr_start_high", FW'(bus.start), FW'(1));
    check("ovr_frame2", dut_frame(), pack_q(f_ref));

    // Simultaneous: the 16th sample of the next frame arrives with done.
    f_ref.delete();
    for (int i = 0; i < N; i++) begin
      s = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      f_ref.push_back(s);
      if (i == N - 1) check("sim_start_before", FW'(bus.start), FW'(1));
      cycle(1'b1, s, i == N - 1, "sim");
    end
    check("sim_start_gap", FW'(bus.start), '0);
    cycle(1'b0, '0, 1'b0, "sim_swap");
    check("sim_start_again", FW'(bus.start), FW'(1));
    check("sim_frame", dut_frame(), pack_q(f_ref));
`ifdef FRAME_DROP_COUNT_EN
    check("sim_no_drop", FW'(bus.drop_count), FW'(3));
`endif

    // Reset mid-frame, asserted between clock edges.
    for (int i = 0; i < 7; i++) cycle(1'b1, WIDTH'(i + 100), 1'b0, "pre_rst");
    #2 rst = 1'b0;
    #1;
    reset_outputs_zero("async_rst");
    model_reset();
    bus.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= N; i++) cycle(1'b1, WIDTH'(i), 1'b0, "post_rst");
    cycle(1'b0, '0, 1'b0, "post_rst_swap");
    check("post_rst_f0",  FW'(bus.frame_samples[0]),  FW'(1));
    check("post_rst_f15", FW'(bus.frame_samples[15]), FW'(16));
    check("post_rst_start", FW'(bus.start), FW'(1));
    cycle(1'b0, '0, 1'b1, "post_rst_done");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0,
            WIDTH'($urandom_range(0, (1 << WIDTH) - 1)),
            $urandom_range(0, 9) == 0, "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
